// File: rtl/ctrl_unit_pkg.sv
// Shared types for the ctrl_unit sequencer: FSM states, opcode and ALU encodings, decoded-instruction bundle.
package ctrl_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_RD_A, S_RD_B, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_INV  = 4'h5;
    localparam logic [3:0] OP_LOAD = 4'h8;
    localparam logic [3:0] OP_INC  = 4'hA;
    localparam logic [3:0] OP_DEC  = 4'hB;
    localparam logic [3:0] OP_HLT  = 4'hC;
    localparam logic [3:0] OP_JNZ  = 4'hE;
    localparam logic [3:0] OP_JMP  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_INV = 3'b101;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;

    // Path class selects which execute states an instruction walks through.
    typedef enum logic [2:0] {
        P_NOP, P_ALU2, P_ALU1, P_LOAD, P_JMP, P_JNZ, P_HLT, P_ILL
    } path_t;

    typedef struct packed {
        path_t      path;
        logic [2:0] alu_op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       b_one;
        logic [7:0] imm;
    } dec_t;

endpackage

// File: rtl/ctrl_unit_if.sv
// Instruction-fetch, register-file and ALU signals between ctrl_unit (master) and the datapath (slave).
interface ctrl_unit_if #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
);
    logic [PC_W-1:0]   pc_o;
    logic              ir_en;
    logic [15:0]       ir_data_i;
    logic [1:0]        rf_addr;
    logic              rf_rd;
    logic              rf_wr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;

    modport master (
        output pc_o, ir_en, rf_addr, rf_rd, rf_wr, rf_wdata, alu_op, alu_a, alu_b,
        input  ir_data_i, rf_rdata, alu_y
    );

    modport slave (
        input  pc_o, ir_en, rf_addr, rf_rd, rf_wr, rf_wdata, alu_op, alu_a, alu_b,
        output ir_data_i, rf_rdata, alu_y
    );
endinterface

// File: rtl/ctrl_unit_decoder.sv
// Combinational IR -> path class, ALU op, register selects, immediate; zero latency, no handshake.
// CTRL_ILLEGAL_TRAP_EN turns undefined opcodes into the trapping P_ILL class instead of P_NOP.
module instr_decoder
    import ctrl_unit_pkg::*;
(
    input  logic [15:0] ir_i,
    output dec_t        dec_o
);
    logic [3:0] op;
    logic       unused_bits;

    assign op          = ir_i[OP_LSB +: 4];
    assign unused_bits = ^ir_i[11:10];

    always_comb begin
        dec_o.path   = P_NOP;
        dec_o.alu_op = ALU_ADD;
        dec_o.rd     = ir_i[RD_LSB  +: 2];
        dec_o.ra     = ir_i[RS1_LSB +: 2];
        dec_o.rb     = ir_i[RS2_LSB +: 2];
        dec_o.b_one  = 1'b0;
        dec_o.imm    = ir_i[7:0];
        case (op)
            OP_ADD:  begin dec_o.path = P_ALU2; dec_o.alu_op = ALU_ADD; end
            OP_SUB:  begin dec_o.path = P_ALU2; dec_o.alu_op = ALU_SUB; end
            OP_AND:  begin dec_o.path = P_ALU2; dec_o.alu_op = ALU_AND; end
            OP_OR:   begin dec_o.path = P_ALU2; dec_o.alu_op = ALU_OR;  end
            OP_XOR:  begin dec_o.path = P_ALU2; dec_o.alu_op = ALU_XOR; end
            OP_INV:  begin dec_o.path = P_ALU1; dec_o.alu_op = ALU_INV; end
            // INC/DEC/JNZ read their own destination register as operand A.
            OP_INC:  begin
                dec_o.path = P_ALU1; dec_o.alu_op = ALU_ADD;
                dec_o.ra = ir_i[RD_LSB +: 2]; dec_o.b_one = 1'b1;
            end
            OP_DEC:  begin
                dec_o.path = P_ALU1; dec_o.alu_op = ALU_SUB;
                dec_o.ra = ir_i[RD_LSB +: 2]; dec_o.b_one = 1'b1;
            end
            OP_JNZ:  begin dec_o.path = P_JNZ; dec_o.ra = ir_i[RD_LSB +: 2]; end
            OP_LOAD: dec_o.path = P_LOAD;
            OP_JMP:  dec_o.path = P_JMP;
            OP_HLT:  dec_o.path = P_HLT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default: dec_o.path = P_ILL;
`else
            default: dec_o.path = P_NOP;
`endif
        endcase
    end
endmodule

// File: rtl/ctrl_unit.sv
// Fetch/decode/execute sequencer, 2-6 cycles per instruction; run low parks in IDLE at the next fetch boundary.
// Optional CTRL_ILLEGAL_TRAP_EN: undefined opcodes set the sticky illegal flag and halt.
module ctrl_unit
    import ctrl_unit_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              DATA_W   = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    ctrl_unit_if.master bus,
    output logic        halted,
    output logic        illegal
);
    state_t            state_q, state_d, fetch_or_idle;
    logic [PC_W-1:0]   pc_q, pc_d, target;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, wdata_q, wdata_d;
    dec_t              dec;

    instr_decoder u_dec (.ir_i(ir_q), .dec_o(dec));

    assign target        = PC_W'(dec.imm);
    assign fetch_or_idle = run ? S_FETCH : S_IDLE;
    assign bus.pc_o      = pc_q;
    assign bus.rf_wdata  = wdata_q;
    assign halted        = (state_q == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        wdata_d     = wdata_q;
        bus.ir_en   = 1'b0;
        bus.rf_rd   = 1'b0;
        bus.rf_wr   = 1'b0;
        bus.rf_addr = '0;
        bus.alu_op  = ALU_ADD;
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        case (state_q)
            S_IDLE:  state_d = fetch_or_idle;
            S_FETCH: begin
                bus.ir_en = 1'b1;
                ir_d      = bus.ir_data_i;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                pc_d = pc_q + PC_W'(1);
                // Single-operand ops use a constant B: 1 for INC/DEC, 0 for INV.
                b_d  = dec.b_one ? DATA_W'(1) : '0;
                case (dec.path)
                    P_ALU2, P_ALU1, P_JNZ: state_d = S_RD_A;
                    P_LOAD: begin
                        wdata_d = DATA_W'(dec.imm);
                        state_d = S_WB;
                    end
                    P_JMP: begin
                        pc_d    = target;
                        state_d = fetch_or_idle;
                    end
                    P_HLT, P_ILL: state_d = S_HALT;
                    default:      state_d = fetch_or_idle;
                endcase
            end
            S_RD_A: begin
                bus.rf_rd   = 1'b1;
                bus.rf_addr = dec.ra;
                a_d         = bus.rf_rdata;
                state_d     = (dec.path == P_ALU2) ? S_RD_B : S_EXEC;
            end
            S_RD_B: begin
                bus.rf_rd   = 1'b1;
                bus.rf_addr = dec.rb;
                b_d         = bus.rf_rdata;
                state_d     = S_EXEC;
            end
            S_EXEC: begin
                if (dec.path == P_JNZ) begin
                    if (a_q != '0) pc_d = target;
                    state_d = fetch_or_idle;
                end else begin
                    bus.alu_op = dec.alu_op;
                    bus.alu_a  = a_q;
                    bus.alu_b  = b_q;
                    wdata_d    = bus.alu_y;
                    state_d    = S_WB;
                end
            end
            S_WB: begin
                bus.rf_wr   = 1'b1;
                bus.rf_addr = dec.rd;
                state_d     = fetch_or_idle;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | ((state_q == S_DECODE) && (dec.path == P_ILL));
    assign illegal   = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: directed programs, expected fetches/writes queued, monitor compares.
module tb_ctrl_unit;
    import ctrl_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic halted, illegal;

    always #5 clk = ~clk;

    ctrl_unit_if #(.PC_W(8), .DATA_W(8)) bus ();

    ctrl_unit #(.PC_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .bus     (bus.master),
        .halted  (halted),
        .illegal (illegal)
    );

    // Datapath environment: instruction ROM, register file and ALU.
    logic [15:0] imem [256];
    logic [7:0]  regs [4];

    assign bus.ir_data_i = imem[bus.pc_o];
    assign bus.rf_rdata  = regs[bus.rf_addr];

    always_comb begin
        case (bus.alu_op)
            3'b000:  bus.alu_y = bus.alu_a + bus.alu_b;
            3'b001:  bus.alu_y = bus.alu_a - bus.alu_b;
            3'b010:  bus.alu_y = bus.alu_a & bus.alu_b;
            3'b011:  bus.alu_y = bus.alu_a | bus.alu_b;
            3'b100:  bus.alu_y = bus.alu_a ^ bus.alu_b;
            3'b101:  bus.alu_y = ~bus.alu_a;
            default: bus.alu_y = 8'h00;
        endcase
    end

    always @(posedge clk) if (rst_n && bus.rf_wr) regs[bus.rf_addr] <= bus.rf_wdata;

    typedef struct { logic [7:0] pc; int gap; } fetch_t;
    typedef struct { logic [1:0] addr; logic [7:0] data; } wr_t;

    fetch_t exp_f[$];
    wr_t    exp_w[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fetch = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic pf(input logic [7:0] pc, input int gap);
        fetch_t f;
        f.pc = pc; f.gap = gap;
        exp_f.push_back(f);
    endtask

    task automatic pw(input logic [1:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp_w.push_back(w);
    endtask

    // Monitor: every fetch and register write must match the head of its queue.
    always @(negedge clk) begin
        fetch_t f;
        wr_t    w;
        cyc = cyc + 1;
        if (rst_n && bus.ir_en) begin
            if (exp_f.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_fetch actual_pc=%0h required=no fetch", bus.pc_o);
            end else begin
                f = exp_f.pop_front();
                check("fetch_pc", 32'(bus.pc_o), 32'(f.pc));
                if (f.gap != 0) check("fetch_gap", 32'(cyc - last_fetch), 32'(f.gap));
            end
            last_fetch = cyc;
        end
        if (rst_n && bus.rf_wr) begin
            if (exp_w.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write actual_addr=%0h data=%0h required=no write",
                         bus.rf_addr, bus.rf_wdata);
            end else begin
                w = exp_w.pop_front();
                check("wr_addr", 32'(bus.rf_addr), 32'(w.addr));
                check("wr_data", 32'(bus.rf_wdata), 32'(w.data));
            end
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hC000;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",     32'(bus.pc_o),     32'h00);
        check("rst_ir_en",  32'(bus.ir_en),    32'h0);
        check("rst_rf_wr",  32'(bus.rf_wr),    32'h0);
        check("rst_rf_rd",  32'(bus.rf_rd),    32'h0);
        check("rst_wdata",  32'(bus.rf_wdata), 32'h00);
        check("rst_halted", 32'(halted),       32'h0);
        check("rst_illegal",32'(illegal),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic finish_prog(input string tag, input int max);
        int n = 0;
        while (!halted && n < max) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_halted"},     32'(halted),       32'h1);
        check({tag, "_fetch_left"}, 32'(exp_f.size()), 32'h0);
        check({tag, "_write_left"}, 32'(exp_w.size()), 32'h0);
        exp_f.delete();
        exp_w.delete();
    endtask

    initial begin
        int n;
        logic [7:0] saved;

        clear_imem();
        do_reset();

        // Every ALU op, LOAD, INV/INC constants and subtraction wrap.
        imem[0]  = 16'h8105;  imem[1]  = 16'h8003;  imem[2]  = 16'h0201;
        imem[3]  = 16'h1310;  imem[4]  = 16'h2312;  imem[5]  = 16'h3312;
        imem[6]  = 16'h4301;  imem[7]  = 16'h5300;  imem[8]  = 16'hA300;
        imem[9]  = 16'h1023;  imem[10] = 16'hC000;
        pf(8'h00, 0); pf(8'h01, 3); pf(8'h02, 3); pf(8'h03, 6); pf(8'h04, 6); pf(8'h05, 6);
        pf(8'h06, 6); pf(8'h07, 6); pf(8'h08, 5); pf(8'h09, 5); pf(8'h0A, 6);
        pw(2'd1, 8'h05); pw(2'd0, 8'h03); pw(2'd2, 8'h08); pw(2'd3, 8'h02); pw(2'd3, 8'h00);
        pw(2'd3, 8'h0D); pw(2'd3, 8'h06); pw(2'd3, 8'hFC); pw(2'd3, 8'hFD); pw(2'd0, 8'h0B);
        run = 1'b1;
        finish_prog("alu", 300);
        check("alu_halt_pc", 32'(bus.pc_o), 32'h0B);

        // DEC/JNZ loop runs three times then falls through.
        do_reset();
        clear_imem();
        imem[0] = 16'h8003; imem[1] = 16'hB000; imem[2] = 16'hE001; imem[3] = 16'hC000;
        pf(8'h00, 0); pf(8'h01, 3); pf(8'h02, 5); pf(8'h01, 4); pf(8'h02, 5);
        pf(8'h01, 4); pf(8'h02, 5); pf(8'h03, 4);
        pw(2'd0, 8'h03); pw(2'd0, 8'h02); pw(2'd0, 8'h01); pw(2'd0, 8'h00);
        run = 1'b1;
        finish_prog("loop", 300);
        check("loop_halt_pc", 32'(bus.pc_o), 32'h04);

        // HALT absorbs run toggling; any fetch here is flagged by the monitor.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            run = i[0];
        end
        #1;
        check("halt_pc_frozen", 32'(bus.pc_o), 32'h04);
        check("halt_sticky",    32'(halted),   32'h1);

        // JMP to 0xFF, PC wraps to 0x00; run dropped during JMP decode parks in IDLE.
        do_reset();
        clear_imem();
        imem[0] = 16'hF0FF; imem[255] = 16'h8207;
        pf(8'h00, 0); pf(8'hFF, 2); pf(8'h00, 3);
        pw(2'd2, 8'h07);
        run = 1'b1;
        n = 0;
        while (exp_f.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        run = 1'b0;
        check("wrap_fetches_seen", 32'(exp_f.size()), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("wrap_idle_pc",     32'(bus.pc_o),     32'hFF);
        check("wrap_idle_ir_en",  32'(bus.ir_en),    32'h0);
        check("wrap_not_halted",  32'(halted),       32'h0);
        check("wrap_write_left",  32'(exp_w.size()), 32'h0);
        exp_f.delete();
        exp_w.delete();

        // Reset asserted during WB drops the write at once.
        do_reset();
        clear_imem();
        imem[0] = 16'h8155;
        saved = regs[1];
        pf(8'h00, 0);
        run = 1'b1;
        n = 0;
        while (!bus.rf_wr && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wb_reached", 32'(bus.rf_wr), 32'h1);
        rst_n = 1'b0;
        #1;
        check("wb_rst_rf_wr", 32'(bus.rf_wr),    32'h0);
        check("wb_rst_pc",    32'(bus.pc_o),     32'h00);
        check("wb_rst_wdata", 32'(bus.rf_wdata), 32'h00);
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("wb_write_dropped", 32'(regs[1]),      32'(saved));
        check("wb_fetch_left",    32'(exp_f.size()), 32'h0);
        exp_f.delete();

        // Undefined opcode 0x9000: trap with the macro, plain 2-cycle NOP without.
        do_reset();
        clear_imem();
        imem[0] = 16'h9000; imem[1] = 16'hC000;
`ifdef CTRL_ILLEGAL_TRAP_EN
        pf(8'h00, 0);
        run = 1'b1;
        finish_prog("ill", 50);
        check("ill_flag", 32'(illegal), 32'h1);
`else
        pf(8'h00, 0); pf(8'h01, 2);
        run = 1'b1;
        finish_prog("ill", 50);
        check("ill_flag",    32'(illegal),  32'h0);
        check("ill_halt_pc", 32'(bus.pc_o), 32'h02);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
